// File: rtl/lock_pkg.sv
// Shared types, defaults and width helpers for the parametrised code lock.
package lock_pkg;

    typedef enum logic [1:0] {
        ST_ENTRY    = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_PROGRAM  = 2'd2,
        ST_LOCKOUT  = 2'd3
    } state_e;

    localparam int unsigned DEF_DATA_W      = 4;
    localparam int unsigned DEF_CODE_LEN    = 7;
    localparam int unsigned DEF_MAX_FAILS   = 3;
    localparam int unsigned DEF_LOCKOUT_CYC = 1024;
    localparam logic [27:0] DEF_CODE        = 28'h1234567;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/param_code_lock_fsm_if.sv
// Digit/program inputs and status outputs of the code lock.
interface param_code_lock_fsm_if #(
    parameter int unsigned DATA_W    = lock_pkg::DEF_DATA_W,
    parameter int unsigned CODE_LEN  = lock_pkg::DEF_CODE_LEN,
    parameter int unsigned MAX_FAILS = lock_pkg::DEF_MAX_FAILS
);
    localparam int unsigned FAIL_W = lock_pkg::cnt_width(MAX_FAILS + 1);

    logic              i_set_data;
    logic              i_prog;
    logic [DATA_W-1:0] iv_data;
    logic [CODE_LEN:0] o_acknowledge;
    logic              o_locked_out;
    logic [FAIL_W-1:0] ov_fail_cnt;

    modport master (
        output i_set_data, i_prog, iv_data,
        input  o_acknowledge, o_locked_out, ov_fail_cnt
    );

    modport slave (
        input  i_set_data, i_prog, iv_data,
        output o_acknowledge, o_locked_out, ov_fail_cnt
    );
endinterface

// File: rtl/strobe_edge_det.sv
// Rising-edge detector for the digit strobe; the enable only gates the pulse.
module strobe_edge_det (
    input  logic clk,
    input  logic i_Rst,
    input  logic i_sig,
    input  logic i_CE,
    output logic o_stb
);
    logic edge_q;

    // Track the previous strobe level every cycle so edges during i_CE=0 are lost.
    always_ff @(posedge clk) begin
        if (i_Rst) edge_q <= 1'b0;
        else       edge_q <= i_sig;
    end

    assign o_stb = i_sig & ~edge_q & i_CE;
endmodule

// File: rtl/param_code_lock_fsm.sv
// Sequential code lock with programmable code, fail counter and timed lockout.
module param_code_lock_fsm
    import lock_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned CODE_LEN    = DEF_CODE_LEN,
    parameter int unsigned MAX_FAILS   = DEF_MAX_FAILS,
    parameter int unsigned LOCKOUT_CYC = DEF_LOCKOUT_CYC,
    parameter logic [CODE_LEN*DATA_W-1:0] DEFAULT_CODE = DEF_CODE
) (
    input logic clk,
    input logic i_Rst,
    input logic i_CE,
    param_code_lock_fsm_if.slave bus
);
    localparam int unsigned IDX_W  = cnt_width(CODE_LEN);
    localparam int unsigned FAIL_W = cnt_width(MAX_FAILS + 1);
    localparam int unsigned LCNT_W = cnt_width(LOCKOUT_CYC);
    localparam int unsigned ACK_W  = CODE_LEN + 1;

    state_e                           state_q, state_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [FAIL_W-1:0]                fail_q, fail_d;
    logic [LCNT_W-1:0]                lcnt_q, lcnt_d;
    logic [ACK_W-1:0]                 ack_q, ack_d;
    logic                             locked_q, locked_d;
    logic [CODE_LEN-1:0][DATA_W-1:0]  code_q, code_d;

    logic              stb;
    logic [IDX_W-1:0]  pos;
    logic              last;
    logic [FAIL_W-1:0] fail_inc;

    strobe_edge_det u_stb (
        .clk   (clk),
        .i_Rst (i_Rst),
        .i_sig (bus.i_set_data),
        .i_CE  (i_CE),
        .o_stb (stb)
    );

    // Digit k lives at the k-th most significant slot of the code register.
    assign pos      = IDX_W'(CODE_LEN - 1) - idx_q;
    assign last     = (idx_q == IDX_W'(CODE_LEN - 1));
    assign fail_inc = fail_q + FAIL_W'(1);

    // State, counters, code register and registered outputs.
    always_ff @(posedge clk) begin
        if (i_Rst) begin
            state_q  <= ST_ENTRY;
            idx_q    <= '0;
            fail_q   <= '0;
            lcnt_q   <= '0;
            ack_q    <= '0;
            locked_q <= 1'b0;
            code_q   <= DEFAULT_CODE;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            fail_q   <= fail_d;
            lcnt_q   <= lcnt_d;
            ack_q    <= ack_d;
            locked_q <= locked_d;
            code_q   <= code_d;
        end
    end

    // Next-state and next-output logic; everything holds unless an event fires.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        fail_d   = fail_q;
        lcnt_d   = lcnt_q;
        ack_d    = ack_q;
        locked_d = locked_q;
        code_d   = code_q;
        unique case (state_q)
            ST_ENTRY: begin
                if (stb) begin
                    if (bus.iv_data == code_q[pos]) begin
                        if (last) begin
                            state_d = ST_UNLOCKED;
                            ack_d   = '1;
                            fail_d  = '0;
                            idx_d   = '0;
                        end else begin
                            ack_d[idx_q] = 1'b1;
                            idx_d        = idx_q + IDX_W'(1);
                        end
                    end else begin
                        ack_d  = '0;
                        idx_d  = '0;
                        fail_d = fail_inc;
                        if (fail_inc == FAIL_W'(MAX_FAILS)) begin
                            state_d  = ST_LOCKOUT;
                            lcnt_d   = LCNT_W'(LOCKOUT_CYC - 1);
                            locked_d = 1'b1;
                        end
                    end
                end
            end
            ST_UNLOCKED: begin
                // A program request wins over a simultaneous strobe.
                if (i_CE && bus.i_prog) begin
                    state_d = ST_PROGRAM;
                    ack_d   = '0;
                    idx_d   = '0;
                end else if (stb) begin
                    state_d = ST_ENTRY;
                    ack_d   = '0;
                    idx_d   = '0;
                end
            end
            ST_PROGRAM: begin
                if (stb) begin
                    code_d[pos] = bus.iv_data;
                    if (last) begin
                        state_d = ST_ENTRY;
                        ack_d   = '0;
                        fail_d  = '0;
                        idx_d   = '0;
                    end else begin
                        ack_d[idx_q] = 1'b1;
                        idx_d        = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_LOCKOUT: begin
                if (i_CE) begin
                    if (lcnt_q == '0) begin
                        state_d  = ST_ENTRY;
                        fail_d   = '0;
                        locked_d = 1'b0;
                    end else begin
                        lcnt_d = lcnt_q - LCNT_W'(1);
                    end
                end
            end
            default: state_d = ST_ENTRY;
        endcase
    end

    assign bus.o_acknowledge = ack_q;
    assign bus.o_locked_out  = locked_q;
    assign bus.ov_fail_cnt   = fail_q;
endmodule

// File: tb/tb_param_code_lock_fsm.sv
// Scoreboard bench for the code lock: default instance plus a small-parameter instance.
module tb_param_code_lock_fsm;
    import lock_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic ce;

    always #5 clk = ~clk;

    param_code_lock_fsm_if #(.DATA_W(4), .CODE_LEN(7), .MAX_FAILS(3)) bus_a ();
    param_code_lock_fsm_if #(.DATA_W(8), .CODE_LEN(3), .MAX_FAILS(1)) bus_b ();

    param_code_lock_fsm #(
        .DATA_W(4), .CODE_LEN(7), .MAX_FAILS(3), .LOCKOUT_CYC(1024),
        .DEFAULT_CODE(28'h1234567)
    ) dut_a (
        .clk   (clk),
        .i_Rst (rst),
        .i_CE  (ce),
        .bus   (bus_a)
    );

    param_code_lock_fsm #(
        .DATA_W(8), .CODE_LEN(3), .MAX_FAILS(1), .LOCKOUT_CYC(4),
        .DEFAULT_CODE(24'hA55A00)
    ) dut_b (
        .clk   (clk),
        .i_Rst (rst),
        .i_CE  (ce),
        .bus   (bus_b)
    );

    typedef struct {
        string      tag;
        logic [7:0] ack;
        logic       lock;
        logic [1:0] fail;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   lock_cyc_a = 0;
    int   lock_cyc_b = 0;
    int   start_cnt;

    int code_def[7] = '{1, 2, 3, 4, 5, 6, 7};
    int code_new[7] = '{10, 11, 12, 13, 14, 15, 0};

    // Count cycles spent with lockout asserted on each instance.
    always @(negedge clk) begin
        if (bus_a.o_locked_out) lock_cyc_a++;
        if (bus_b.o_locked_out) lock_cyc_b++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] prog_mask(input int k);
        return 8'((1 << k) - 1);
    endfunction

    function automatic logic locked(input int sel);
        return (sel == 0) ? bus_a.o_locked_out : bus_b.o_locked_out;
    endfunction

    task automatic set_inputs(input int sel, input logic sd, input logic pg, input logic [7:0] d);
        if (sel == 0) begin
            bus_a.i_set_data = sd;
            bus_a.i_prog     = pg;
            bus_a.iv_data    = d[3:0];
        end else begin
            bus_b.i_set_data = sd;
            bus_b.i_prog     = pg;
            bus_b.iv_data    = d;
        end
    endtask

    task automatic push_exp(input string tag, input logic [7:0] ack, input logic lock,
                            input logic [1:0] fail);
        exp_t e;
        e.tag  = tag;
        e.ack  = ack;
        e.lock = lock;
        e.fail = fail;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input int sel);
        exp_t        e;
        logic [31:0] ack, lk, fc;
        e = sb_q.pop_front();
        if (sel == 0) begin
            ack = 32'(bus_a.o_acknowledge);
            lk  = 32'(bus_a.o_locked_out);
            fc  = 32'(bus_a.ov_fail_cnt);
        end else begin
            ack = 32'(bus_b.o_acknowledge);
            lk  = 32'(bus_b.o_locked_out);
            fc  = 32'(bus_b.ov_fail_cnt);
        end
        check_eq({e.tag, ".ack"},  ack, 32'(e.ack));
        check_eq({e.tag, ".lock"}, lk,  32'(e.lock));
        check_eq({e.tag, ".fail"}, fc,  32'(e.fail));
    endtask

    // One strobe pulse (optionally with i_prog / i_CE), checked the cycle after, then an idle cycle.
    task automatic digit(input int sel, input logic [7:0] d, input logic pg, input string tag,
                         input logic [7:0] ack, input logic lock, input logic [1:0] fail,
                         input logic en = 1'b1);
        ce = en;
        set_inputs(sel, 1'b1, pg, d);
        push_exp(tag, ack, lock, fail);
        @(negedge clk);
        sb_check(sel);
        set_inputs(sel, 1'b0, 1'b0, d);
        ce = 1'b1;
        @(negedge clk);
    endtask

    task automatic enter_code(input int c[7], input logic [1:0] fail0, input string base);
        for (int k = 0; k < 7; k++) begin
            if (k == 6)
                digit(0, 8'(c[k]), 1'b0, $sformatf("%s_d%0d", base, k), 8'hFF, 1'b0, 2'd0);
            else
                digit(0, 8'(c[k]), 1'b0, $sformatf("%s_d%0d", base, k), prog_mask(k + 1), 1'b0, fail0);
        end
    endtask

    task automatic wait_release(input int sel, input string tag);
        int n = 0;
        while (locked(sel) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, ".released"}, 32'(locked(sel)), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        ce  = 1'b1;
        set_inputs(0, 1'b0, 1'b0, 8'h0);
        set_inputs(1, 1'b0, 1'b0, 8'h0);
        repeat (2) @(negedge clk);
        push_exp("rst_a", 8'h00, 1'b0, 2'd0);
        push_exp("rst_b", 8'h00, 1'b0, 2'd0);
        sb_check(0);
        sb_check(1);
        rst = 1'b0;
        @(negedge clk);

        // Default code unlocks, then a strobe relocks.
        enter_code(code_def, 2'd0, "def");
        digit(0, 8'h5, 1'b0, "relock1", 8'h00, 1'b0, 2'd0);

        // Wrong third digit, then retry.
        digit(0, 8'h1, 1'b0, "bad_d0", 8'h01, 1'b0, 2'd0);
        digit(0, 8'h2, 1'b0, "bad_d1", 8'h03, 1'b0, 2'd0);
        digit(0, 8'h9, 1'b0, "bad_d2", 8'h00, 1'b0, 2'd1);
        enter_code(code_def, 2'd1, "retry");
        digit(0, 8'h5, 1'b0, "relock2", 8'h00, 1'b0, 2'd0);

        // Three wrong first digits lock out; strobes are ignored meanwhile.
        digit(0, 8'h0, 1'b0, "lo_f1", 8'h00, 1'b0, 2'd1);
        digit(0, 8'h0, 1'b0, "lo_f2", 8'h00, 1'b0, 2'd2);
        start_cnt = lock_cyc_a;
        digit(0, 8'h0, 1'b0, "lo_f3", 8'h00, 1'b1, 2'd3);
        for (int k = 0; k < 7; k++)
            digit(0, 8'(code_def[k]), 1'b0, $sformatf("lo_ign%0d", k), 8'h00, 1'b1, 2'd3);
        wait_release(0, "lo_a");
        check_eq("lo_len_a", 32'(lock_cyc_a - start_cnt), 32'd1024);
        check_eq("lo_fail_clr_a", 32'(bus_a.ov_fail_cnt), 32'd0);
        check_eq("lo_ack_a", 32'(bus_a.o_acknowledge), 32'd0);
        enter_code(code_def, 2'd0, "post_lo");

        // Program a new code from UNLOCKED.
        ce = 1'b1;
        bus_a.i_prog = 1'b1;
        push_exp("prog_req", 8'h00, 1'b0, 2'd0);
        @(negedge clk);
        sb_check(0);
        bus_a.i_prog = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 7; k++)
            digit(0, 8'(code_new[k]), 1'b0, $sformatf("pgm%0d", k),
                  (k == 6) ? 8'h00 : prog_mask(k + 1), 1'b0, 2'd0);
        digit(0, 8'h1, 1'b0, "old_code", 8'h00, 1'b0, 2'd1);
        enter_code(code_new, 2'd1, "new_code");

        // Edges while disabled are lost.
        digit(0, 8'h3, 1'b0, "ce0_unl", 8'hFF, 1'b0, 2'd0, 1'b0);
        digit(0, 8'h3, 1'b0, "relock3", 8'h00, 1'b0, 2'd0);
        digit(0, 8'hA, 1'b0, "ce0_ent", 8'h00, 1'b0, 2'd0, 1'b0);
        enter_code(code_new, 2'd0, "ce_after");

        // Program request beats a simultaneous strobe; reset mid-programming restores the default.
        digit(0, 8'h9, 1'b1, "prog_pri", 8'h00, 1'b0, 2'd0);
        digit(0, 8'h1, 1'b0, "pgm_p0", 8'h01, 1'b0, 2'd0);
        digit(0, 8'h2, 1'b0, "pgm_p1", 8'h03, 1'b0, 2'd0);
        digit(0, 8'h3, 1'b0, "pgm_p2", 8'h07, 1'b0, 2'd0);
        rst = 1'b1;
        push_exp("rst_mid", 8'h00, 1'b0, 2'd0);
        @(negedge clk);
        sb_check(0);
        rst = 1'b0;
        @(negedge clk);
        enter_code(code_def, 2'd0, "post_rst");

        // Small-parameter instance: 3-digit code, single fail locks out for 4 cycles.
        digit(1, 8'hA5, 1'b0, "b_d0", 8'h01, 1'b0, 2'd0);
        digit(1, 8'h5A, 1'b0, "b_d1", 8'h03, 1'b0, 2'd0);
        digit(1, 8'h00, 1'b0, "b_d2", 8'h0F, 1'b0, 2'd0);
        digit(1, 8'h00, 1'b0, "b_relock", 8'h00, 1'b0, 2'd0);
        start_cnt = lock_cyc_b;
        digit(1, 8'h11, 1'b0, "b_fail", 8'h00, 1'b1, 2'd1);
        wait_release(1, "lo_b");
        check_eq("lo_len_b", 32'(lock_cyc_b - start_cnt), 32'd4);
        check_eq("lo_fail_clr_b", 32'(bus_b.ov_fail_cnt), 32'd0);
        digit(1, 8'hA5, 1'b0, "b2_d0", 8'h01, 1'b0, 2'd0);
        digit(1, 8'h5A, 1'b0, "b2_d1", 8'h03, 1'b0, 2'd0);
        digit(1, 8'h00, 1'b0, "b2_d2", 8'h0F, 1'b0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
